pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter register and fetch-control stage directly downstream of the PC incrementer. It holds the current PC and feeds it both to the incrementer and to instruction memory. Each cycle it selects the next PC from the incremented value, a branch target or a jump target. It also handles pipeline stalls, halt/resume, and redirects that arrive during a stall.

## Interface
- PC_W, 7, PC width in bits; matches the incrementer width
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 8, width of the fetch counter

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_addOut  input  PC_W  incremented PC (pc_out + 1, modulo 2^PC_W) from the incrementer
- branch_taken  input  1  branch resolved taken this cycle
- branch_target  input  PC_W  branch destination
- jump  input  1  unconditional jump this cycle
- jump_target  input  PC_W  jump destination
- stall  input  1  hold PC this cycle
- halt  input  1  request halt
- resume  input  1  leave HALTED
- pc_out  output  PC_W  current PC (registered); drives incrementer and instruction memory
- fetch_valid  output  1  pc_out is a valid fetch address this cycle
- wrap  output  1  one-cycle pulse: PC wrapped from all-ones to 0
- fetch_count  output  CNT_W  saturating count of PC updates

## Operation
States and transitions:
- IDLE: entered on reset. Always moves to RUN on the next edge; PC is not changed.
- RUN: normal fetch. If halt=1, move to HALTED.
- HALTED: PC is frozen. Move to RUN when resume=1 and halt=0.

Next-PC selection in RUN uses this priority: halt > stall > branch_taken > jump > pending redirect > sequential.
- **halt=1:** PC holds and the state moves to HALTED. A redirect presented in the same cycle is dropped. An existing pending redirect is kept.
- **stall=1:** PC holds.
  - If branch_taken or jump is also asserted, capture its target into the pending register and set pending=1 (branch beats jump).
  - A later redirect during the same stall overwrites the pending register (newest wins).
- **branch_taken=1:** pc ← branch_target; pending cleared.
- **jump=1:** pc ← jump_target; pending cleared.
- **pending=1:** pc ← pending target; pending cleared.
- **Otherwise:** pc ← pc_addOut.

Outputs:
- fetch_valid = (state==RUN) & ~stall & ~halt. This is combinational from state and inputs.
- wrap is registered. It is set for one cycle when the sequential path loads 0 while pc_out is all-ones. A redirect to 0 does not set wrap.
- fetch_count increments on every edge where pc_out changes source (sequential or redirect) while in RUN. It saturates at 2^CNT_W−1.
- In HALTED, branch_taken, jump and stall are ignored.

## Timing
- Reset values: pc_out=RESET_PC, fetch_valid=0, wrap=0, fetch_count=0, pending=0, state=IDLE.
- First edge after rst falls: state=RUN, and fetch_valid=1 at RESET_PC.
- A redirect presented in cycle N is visible on pc_out after edge N (1-cycle latency).
- A pending redirect is applied on the edge that ends the first non-stalled RUN cycle. fetch_valid is 1 in that cycle with the old PC.
- halt asserted in cycle N: fetch_valid=0 in cycle N, and state=HALTED after edge N.
- resume in cycle N: state=RUN after edge N, and PC resumes from the held value.
- halt and resume together in HALTED: stay HALTED.
- rst asserted mid-operation: all state returns to reset values on that edge, including pending and the counter.

## Structure
- Shared package pc_pkg holds:
  - the state typedef (IDLE, RUN, HALTED)
  - default PC_W and CNT_W
  - RESET_PC
- No sub-module. The incrementer stays a separate instance at the datapath top level, wired pc_out → pc_addIn and pc_addOut → pc_addOut.

## Test plan
- **Reset release:** rst high for 2 cycles, then low → pc_out=0 and fetch_valid=0 in the first cycle. After one edge, fetch_valid=1 and pc sequence is 0,1,2,3.
- **Branch:** branch_taken=1 with target=0x40 while at pc=5 → next pc_out=0x40, then 0x41. fetch_count increments each edge.
- **Stalled redirect:**
  - stall=1 for 3 cycles at pc=10, with jump=1 and target=0x20 in stall cycle 1, then branch target=0x30 in stall cycle 2.
  - Required: pc_out holds 10 throughout the stall, then one fetch at 10, then 0x30.
- **Wrap:** run sequentially from pc=0x7E → sequence 0x7E, 0x7F, 0x00. wrap=1 only in the cycle pc_out=0x00. A jump to 0 never sets wrap.
- **Halt/resume:**
  - halt at pc=7 → fetch_valid=0 and pc holds 7. Branches presented while HALTED are ignored.
  - halt+resume together → stays HALTED.
  - resume alone → RUN, fetching 7 then 8.
- **Saturation and mid-run reset:** 300 sequential updates → fetch_count=255. Then rst for one cycle → all outputs return to reset values.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default sizing for the PC register / fetch-control stage.
// Imported by pc_fetch_ctrl and by anything that needs to decode its state.
package pc_pkg;

    localparam int PC_W_DFLT     = 7;
    localparam int CNT_W_DFLT    = 8;
    localparam int RESET_PC_DFLT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch control: next-PC selection, stall-time
// redirect capture, halt/resume, sequential wrap flag and a saturating fetch count.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int PC_W     = PC_W_DFLT,
    parameter int CNT_W    = CNT_W_DFLT,
    parameter int RESET_PC = RESET_PC_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc_addOut,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    output logic [PC_W-1:0]  pc_out,
    output logic             fetch_valid,
    output logic             wrap,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            pend;
    logic [PC_W-1:0] pend_tgt;
    logic            wrap_q;
    logic [CNT_W-1:0] cnt_q;

    logic            redir_vld;
    logic [PC_W-1:0] redir_tgt;
    logic            seq_wrap;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Branch outranks jump both for immediate redirects and for stall capture.
    always_comb begin
        redir_vld = branch_taken | jump;
        redir_tgt = branch_taken ? branch_target : jump_target;
        seq_wrap  = (&pc_q) && (pc_addOut == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC_V;
            pend     <= 1'b0;
            pend_tgt <= '0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wrap_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (halt) begin
                        // Same-cycle redirect is dropped; an older pending one survives.
                        state <= HALTED;
                    end else if (stall) begin
                        if (redir_vld) begin
                            pend     <= 1'b1;
                            pend_tgt <= redir_tgt;
                        end
                    end else begin
                        pend  <= 1'b0;
                        cnt_q <= sat_inc(cnt_q);
                        if (redir_vld) begin
                            pc_q <= redir_tgt;
                        end else if (pend) begin
                            pc_q <= pend_tgt;
                        end else begin
                            pc_q   <= pc_addOut;
                            wrap_q <= seq_wrap;
                        end
                    end
                end
                HALTED: begin
                    if (resume && !halt) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pc_out      = pc_q;
    assign wrap        = wrap_q;
    assign fetch_count = cnt_q;
    assign fetch_valid = (state == RUN) && !stall && !halt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, each compared
// against a priority-list reference model of the fetch stage.
module tb_pc_fetch_ctrl;

    localparam int PW = 7;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pc_add;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          jump;
    logic [PW-1:0] jump_target;
    logic          stall;
    logic          halt;
    logic          resume;
    logic [PW-1:0] pc_out;
    logic          fetch_valid;
    logic          wrap;
    logic [CW-1:0] fetch_count;

    int checks = 0;
    int passes = 0;

    // Reference model: mode 0=idle, 1=running, 2=halted
    int m_mode;
    int m_pc;
    bit m_pend;
    int m_ptgt;
    int m_cnt;
    bit m_wrap;

    always #5 clk = ~clk;

    // The incrementer that sits beside the DUT in the datapath
    assign pc_add = pc_out + 7'd1;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addOut     (pc_add),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .pc_out        (pc_out),
        .fetch_valid   (fetch_valid),
        .wrap          (wrap),
        .fetch_count   (fetch_count)
    );

    function automatic bit exp_fv();
        return (m_mode == 1) && !stall && !halt;
    endfunction

    task automatic clear_inputs();
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        stall         = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
    endtask

    // Advance one clock edge and apply the same inputs to the model.
    task automatic tick();
        int nxt;
        @(posedge clk);
        m_wrap = 1'b0;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_pend = 0; m_ptgt = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (resume && !halt) m_mode = 1;
        end else if (halt) begin
            m_mode = 2;
        end else if (stall) begin
            if (branch_taken) begin m_pend = 1; m_ptgt = branch_target; end
            else if (jump) begin m_pend = 1; m_ptgt = jump_target; end
        end else begin
            if (branch_taken) nxt = branch_target;
            else if (jump) nxt = jump_target;
            else if (m_pend) nxt = m_ptgt;
            else begin
                nxt = (m_pc + 1) % (1 << PW);
                m_wrap = (m_pc == (1 << PW) - 1);
            end
            m_pend = 0;
            m_pc = nxt;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic redirect_to(input int tgt);
        clear_inputs();
        jump = 1'b1; jump_target = PW'(tgt);
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if ({pc_out, fetch_valid, wrap, fetch_count} !== {7'd0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_values: got pc=%0h fv=%0b wrap=%0b cnt=%0d want 0/0/0/0", pc_out, fetch_valid, wrap, fetch_count);
        else passes++;
        rst = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0 || pc_out !== 7'd0)
            $display("FAIL reset_first_cycle: got pc=%0h fv=%0b want pc=0 fv=0", pc_out, fetch_valid);
        else passes++;
        tick();
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 7'd0)
            $display("FAIL reset_run_entry: got pc=%0h fv=%0b want pc=0 fv=1", pc_out, fetch_valid);
        else passes++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc_out !== PW'(i) || fetch_count !== CW'(i))
                $display("FAIL reset_seq_%0d: got pc=%0h cnt=%0d want pc=%0h cnt=%0d", i, pc_out, fetch_count, i, i);
            else passes++;
        end
    endtask

    task automatic test_branch();
        int c0;
        redirect_to(5);
        c0 = m_cnt;
        branch_taken = 1'b1; branch_target = 7'h40;
        tick();
        clear_inputs();
        checks++; if (pc_out !== 7'h40 || fetch_count !== CW'(c0 + 1))
            $display("FAIL branch_target: got pc=%0h cnt=%0d want pc=40 cnt=%0d", pc_out, fetch_count, c0 + 1);
        else passes++;
        tick();
        checks++; if (pc_out !== 7'h41 || fetch_count !== CW'(c0 + 2))
            $display("FAIL branch_follow: got pc=%0h cnt=%0d want pc=41 cnt=%0d", pc_out, fetch_count, c0 + 2);
        else passes++;
    endtask

    task automatic test_stalled_redirect();
        redirect_to(10);
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            stall = 1'b1;
            if (i == 0) begin jump = 1'b1; jump_target = 7'h20; end
            if (i == 1) begin branch_taken = 1'b1; branch_target = 7'h30; end
            #1;
            checks++; if (fetch_valid !== 1'b0)
                $display("FAIL stall_fv_%0d: got %0b want 0", i, fetch_valid);
            else passes++;
            tick();
            checks++; if (pc_out !== 7'd10)
                $display("FAIL stall_hold_%0d: got pc=%0h want a", i, pc_out);
            else passes++;
        end
        clear_inputs();
        #1;
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 7'd10)
            $display("FAIL stall_release: got pc=%0h fv=%0b want pc=a fv=1", pc_out, fetch_valid);
        else passes++;
        tick();
        checks++; if (pc_out !== 7'h30)
            $display("FAIL stall_pending_apply: got pc=%0h want 30", pc_out);
        else passes++;
        tick();
        checks++; if (pc_out !== 7'h31)
            $display("FAIL stall_pending_cleared: got pc=%0h want 31", pc_out);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_pc [4];
        logic          exp_wr [4];
        exp_pc = '{7'h7E, 7'h7F, 7'h00, 7'h01};
        exp_wr = '{1'b0, 1'b0, 1'b1, 1'b0};
        redirect_to(7'h7E);
        for (int i = 0; i < 4; i++) begin
            checks++; if (pc_out !== exp_pc[i] || wrap !== exp_wr[i])
                $display("FAIL wrap_seq_%0d: got pc=%0h wrap=%0b want pc=%0h wrap=%0b", i, pc_out, wrap, exp_pc[i], exp_wr[i]);
            else passes++;
            tick();
        end
        redirect_to(7'h7F);
        redirect_to(0);
        checks++; if (pc_out !== 7'h00 || wrap !== 1'b0)
            $display("FAIL wrap_jump_zero: got pc=%0h wrap=%0b want pc=0 wrap=0", pc_out, wrap);
        else passes++;
    endtask

    task automatic test_halt_resume();
        redirect_to(7);
        halt = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0)
            $display("FAIL halt_fv: got %0b want 0", fetch_valid);
        else passes++;
        tick();
        clear_inputs();
        branch_taken = 1'b1; branch_target = 7'h55; stall = 1'b1;
        tick();
        checks++; if (pc_out !== 7'd7 || fetch_valid !== 1'b0)
            $display("FAIL halt_ignores_branch: got pc=%0h fv=%0b want pc=7 fv=0", pc_out, fetch_valid);
        else passes++;
        clear_inputs();
        halt = 1'b1; resume = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++; if (fetch_valid !== 1'b0 || pc_out !== 7'd7)
            $display("FAIL halt_and_resume: got pc=%0h fv=%0b want pc=7 fv=0", pc_out, fetch_valid);
        else passes++;
        resume = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++; if (fetch_valid !== 1'b1 || pc_out !== 7'd7)
            $display("FAIL resume_fetch: got pc=%0h fv=%0b want pc=7 fv=1", pc_out, fetch_valid);
        else passes++;
        tick();
        checks++; if (pc_out !== 7'd8)
            $display("FAIL resume_next: got pc=%0h want 8", pc_out);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            halt          = ($urandom_range(0, 15) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_target = PW'($urandom);
            jump_target   = PW'($urandom);
            #1;
            checks++; if (fetch_valid !== exp_fv())
                $display("FAIL random_fv_%0d: got %0b want %0b", i, fetch_valid, exp_fv());
            else passes++;
            tick();
            checks++; if ({pc_out, wrap, fetch_count} !== {PW'(m_pc), m_wrap, CW'(m_cnt)})
                $display("FAIL random_state_%0d: got pc=%0h wrap=%0b cnt=%0d want pc=%0h wrap=%0b cnt=%0d",
                         i, pc_out, wrap, fetch_count, m_pc, m_wrap, m_cnt);
            else passes++;
        end
        clear_inputs();
        halt = 1'b0; resume = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation_reset();
        clear_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) tick();
        checks++; if (fetch_count !== 8'd255 || m_cnt != 255)
            $display("FAIL saturation: got cnt=%0d want 255", fetch_count);
        else passes++;
        // Leave a pending redirect in flight so the reset must clear it too.
        stall = 1'b1; jump = 1'b1; jump_target = 7'h66;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        checks++; if ({pc_out, fetch_valid, wrap, fetch_count} !== {7'd0, 1'b0, 1'b0, 8'd0})
            $display("FAIL midrun_reset: got pc=%0h fv=%0b wrap=%0b cnt=%0d want 0/0/0/0", pc_out, fetch_valid, wrap, fetch_count);
        else passes++;
        rst = 1'b0;
        tick(); tick();
        checks++; if (pc_out !== 7'd1 || fetch_count !== 8'd1)
            $display("FAIL reset_clears_pending: got pc=%0h cnt=%0d want pc=1 cnt=1", pc_out, fetch_count);
        else passes++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        m_mode = 0; m_pc = 0; m_pend = 0; m_ptgt = 0; m_cnt = 0; m_wrap = 0;
        #1;
        test_reset();
        test_branch();
        test_stalled_redirect();
        test_wrap();
        test_halt_resume();
        test_random();
        test_saturation_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
